// File: rtl/seven_seg_pkg.sv
// Shared types, constants and the leading-zero blank-mask helper for the
// seven-segment scan controller.
package seven_seg_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 8;
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'h0;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Bit i is set when digit i (i >= 1) and every digit above it are zero.
  // Digit 0 is never part of the mask so a zero value still shows one "0".
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [DIGIT_W*MAX_DIGITS-1:0] disp,
    input int                            num_digits
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  upper_zero;
    mask       = '0;
    upper_zero = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < num_digits) begin
        upper_zero = upper_zero && (disp[DIGIT_W*i +: DIGIT_W] == BLANK_CODE);
        mask[i]    = upper_zero;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_prescaler.sv
// Modulo-SCAN_DIV free-running counter; tc is high while the count sits at
// its last value, so it marks the edge on which the digit index advances.
module scan_prescaler #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tc
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] pcnt;

  assign tc = (pcnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst)
      pcnt <= '0;
    else if (tc)
      pcnt <= '0;
    else
      pcnt <= pcnt + 1'b1;
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scan controller for a common-anode seven-segment display:
// latches packed digit codes and walks one active-low anode at a time.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
  input  logic                          blank_lz,
  output logic [DIGIT_W-1:0]            digit_out,
  output logic [NUM_DIGITS-1:0]         an_out,
  output logic                          scan_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIGIT_W*NUM_DIGITS-1:0] disp;
  logic [DIGIT_W*MAX_DIGITS-1:0] disp_ext;
  logic [MAX_DIGITS-1:0]         blank_mask;
  logic [IDX_W-1:0]              idx;
  logic [2:0]                    idx_ext;
  logic                          tc;
  digit_t                        cur_digit;
  logic [NUM_DIGITS-1:0]         an_next;

  scan_prescaler #(
    .SCAN_DIV(SCAN_DIV)
  ) u_prescaler (
    .clk(clk),
    .rst(rst),
    .tc (tc)
  );

  assign disp_ext   = (DIGIT_W*MAX_DIGITS)'(disp);
  assign blank_mask = lz_mask(disp_ext, NUM_DIGITS);
  assign idx_ext    = 3'(idx);

  // A blanked slot still takes its full dwell time; only the anode stays off.
  always_comb begin
    cur_digit = BLANK_CODE;
    an_next   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i))
        cur_digit = disp[DIGIT_W*i +: DIGIT_W];
    end
    if (!(blank_lz && blank_mask[idx_ext]))
      an_next[idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp      <= '0;
      idx       <= '0;
      digit_out <= BLANK_CODE;
      an_out    <= '1;
      scan_tick <= 1'b0;
    end else begin
      if (load)
        disp <= digits_in;
      if (tc)
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      digit_out <= cur_digit;
      an_out    <= an_next;
      scan_tick <= tc;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: a slot-timing reference model pushes
// the expected output per edge, a negedge monitor pops and compares.
module tb_seven_seg_scanner;

  localparam int ND = 4;
  localparam int SD = 4;

  typedef struct {
    logic [3:0] digit;
    logic [3:0] an;
    logic       tick;
    int         cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] digits_in;
  logic        blank_lz;
  logic [3:0]  digit_out;
  logic [3:0]  an_out;
  logic        scan_tick;

  exp_t sb[$];
  int   m_disp[ND];
  int   m_cnt;
  int   cycle;
  int   tests_run;
  int   tests_failed;

  seven_seg_scanner #(
    .NUM_DIGITS(ND),
    .SCAN_DIV  (SD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .digits_in(digits_in),
    .blank_lz (blank_lz),
    .digit_out(digit_out),
    .an_out   (an_out),
    .scan_tick(scan_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the active slot is simply elapsed cycles / SCAN_DIV mod digits.
  task automatic modelStep(input bit r, input bit ld, input logic [15:0] d, input bit bl);
    exp_t e;
    int   slot;
    bit   blanked;
    e.cyc = cycle;
    if (r) begin
      e.digit = 4'h0;
      e.an    = 4'hF;
      e.tick  = 1'b0;
      for (int j = 0; j < ND; j++) m_disp[j] = 0;
      m_cnt = 0;
    end else begin
      slot    = (m_cnt / SD) % ND;
      blanked = bl && (slot >= 1);
      for (int j = slot; j < ND; j++)
        if (m_disp[j] != 0) blanked = 1'b0;
      e.digit = 4'(m_disp[slot]);
      e.an    = blanked ? 4'hF : (4'hF & ~(4'b0001 << slot));
      e.tick  = ((m_cnt % SD) == SD - 1);
      if (ld)
        for (int j = 0; j < ND; j++) m_disp[j] = (d >> (4 * j)) & 16'hF;
      m_cnt++;
    end
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input bit r, input bit ld, input logic [15:0] d, input bit bl);
    rst       = r;
    load      = ld;
    digits_in = d;
    blank_lz  = bl;
    @(posedge clk);
    modelStep(r, ld, d, bl);
    cycle++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit bl);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0000, bl);
  endtask

  task automatic checkOutput(input exp_t e);
    tests_run++;
    if (digit_out !== e.digit || an_out !== e.an || scan_tick !== e.tick) begin
      tests_failed++;
      $display("[TB] FAIL scan_out edge %0d: got digit=%h an=%b tick=%b, expected digit=%h an=%b tick=%b",
               e.cyc, digit_out, an_out, scan_tick, e.digit, e.an, e.tick);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  initial begin
    logic [15:0] rd;
    tests_run    = 0;
    tests_failed = 0;
    cycle        = 0;
    m_cnt        = 0;
    for (int j = 0; j < ND; j++) m_disp[j] = 0;
    rst       = 1'b1;
    load      = 1'b0;
    digits_in = 16'h0000;
    blank_lz  = 1'b0;

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);

    applyStimulus(1'b0, 1'b1, 16'h4321, 1'b0);
    idx_scan: idle(19, 1'b0);

    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0070, 1'b1);
    idle(16, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1);
    idle(16, 1'b1);

    applyStimulus(1'b0, 1'b1, 16'h00A0, 1'b1);
    idle(16, 1'b1);

    // load lands on the terminal-count edge of the digit 0 slot
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h4321, 1'b0);
    idle(2, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h8765, 1'b0);
    idle(8, 1'b0);

    idle(12, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b0);
    idle(8, 1'b0);

    for (int i = 0; i < 400; i++) begin
      for (int j = 0; j < ND; j++)
        rd[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), rd,
                    ($urandom_range(0, 3) != 0));
    end

    #1;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
